vwind_sample_ctrl: RTL and testbench

Downstream stage of the wind-speed generator. It captures the generator's `VWind` word once per simulation step, after the generator's address/ROM pipeline has settled. It screens the captured word for IEEE-754 special values and hands the result to the wind-turbine solver over a valid/ready handshake. Each sample carries a changed flag and the simulation timestamp.

---
 rtl/global_parameter.sv | 18 +
 rtl/vwind_sample_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_vwind_sample_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/global_parameter.sv
// -----------------------------------------------------------------------------
// global_parameter
//   Shared constants for the wind-speed generator chain and its downstream
//   stages: float/time widths, the IEEE-754 single-precision exponent field
//   bounds, and the width of the delivered-sample counter.
// -----------------------------------------------------------------------------
package global_parameter;

  localparam int SINGLE        = 32;  // single-precision float width
  localparam int WIDTH_TIME    = 32;  // simulation-time field width

  // Exponent field of a single-precision float; all ones means NaN or Inf.
  localparam int FP_EXP_MSB    = 30;
  localparam int FP_EXP_LSB    = 23;

  localparam int WIDTH_STEPCNT = 16;  // delivered-sample counter width

endpackage : global_parameter

// File: rtl/vwind_sample_ctrl.sv
// -----------------------------------------------------------------------------
// vwind_sample_ctrl
//   Captures the wind generator's VWind word once per simulation step, after
//   CAP_DELAY cycles of pipeline settling. NaN/Inf words are screened and
//   replaced by the last good value. The sample is then offered to the solver
//   over a valid/ready handshake.
//
// Parameters
//   CAP_DELAY  cycles from sta to a stable VWind (1..15)
//   SW         float data width
//   TW         simulation-time width
//
// Ports
//   clk         in   sole clock
//   rst         in   asynchronous reset, active high
//   sta         in   simulation-step strobe
//   VWind       in   wind speed from the generator (single-precision float)
//   sim_time    in   current simulation time
//   rdy_out     in   solver ready
//   vw_out      out  accepted wind speed
//   t_out       out  sim_time captured with the sample
//   vw_valid    out  sample offered to the solver
//   vw_changed  out  vw_out differs bitwise from the previously delivered sample
//   vw_bad      out  captured word was NaN/Inf; last good value substituted
//   step_cnt    out  count of delivered samples (wraps)
//   overrun     out  sticky: sta arrived while busy
// -----------------------------------------------------------------------------
module vwind_sample_ctrl
  import global_parameter::*;
#(
  parameter int CAP_DELAY = 4,
  parameter int SW        = SINGLE,
  parameter int TW        = WIDTH_TIME
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sta,
  input  logic [SW-1:0]            VWind,
  input  logic [TW-1:0]            sim_time,
  input  logic                     rdy_out,
  output logic [SW-1:0]            vw_out,
  output logic [TW-1:0]            t_out,
  output logic                     vw_valid,
  output logic                     vw_changed,
  output logic                     vw_bad,
  output logic [WIDTH_STEPCNT-1:0] step_cnt,
  output logic                     overrun
);

  localparam int CNT_W = 4;  // holds CAP_DELAY-1 for CAP_DELAY up to 15

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE,
    S_OFFER
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [SW-1:0]            vw_out_q, vw_out_d;
  logic [TW-1:0]            t_out_q, t_out_d;
  logic [SW-1:0]            last_good_q, last_good_d;
  logic                     seen_good_q, seen_good_d;  // a good sample has been delivered since reset
  logic                     valid_q, valid_d;
  logic                     changed_q, changed_d;
  logic                     bad_q, bad_d;
  logic [WIDTH_STEPCNT-1:0] step_cnt_q, step_cnt_d;
  logic                     overrun_q, overrun_d;

  logic capture;
  logic xfer;
  logic is_special;

  assign capture    = (state_q == S_CAPTURE);
  assign xfer       = (state_q == S_OFFER) && rdy_out;
  assign is_special = (VWind[FP_EXP_MSB:FP_EXP_LSB] == '1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge inputs regardless of the order the blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (sta) begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(CAP_DELAY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_CAPTURE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_CAPTURE: state_d = S_OFFER;
      S_OFFER:   if (rdy_out) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: next values of the registered sample outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    vw_out_d    = vw_out_q;
    t_out_d     = t_out_q;
    last_good_d = last_good_q;
    seen_good_d = seen_good_q;
    valid_d     = valid_q;
    changed_d   = changed_q;
    bad_d       = bad_q;
    step_cnt_d  = step_cnt_q;
    // A strobe outside IDLE is dropped but remembered until reset.
    overrun_d   = overrun_q | (sta && (state_q != S_IDLE));

    if (capture) begin
      valid_d = 1'b1;
      t_out_d = sim_time;
      if (is_special) begin
        bad_d     = 1'b1;
        changed_d = 1'b0;
      end else begin
        vw_out_d  = VWind;
        bad_d     = 1'b0;
        // Bitwise compare: +0 vs -0 counts as a change.
        changed_d = !seen_good_q || (VWind != last_good_q);
      end
    end

    if (xfer) begin
      valid_d    = 1'b0;
      step_cnt_d = step_cnt_q + 1'b1;
      if (!bad_q) begin
        last_good_d = vw_out_q;
        seen_good_d = 1'b1;
      end
    end
  end

  // NOTE: these are plain registers, not a memory array, so all of them are
  // cleared by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vw_out_q    <= '0;
      t_out_q     <= '0;
      last_good_q <= '0;
      seen_good_q <= 1'b0;
      valid_q     <= 1'b0;
      changed_q   <= 1'b0;
      bad_q       <= 1'b0;
      step_cnt_q  <= '0;
      overrun_q   <= 1'b0;
    end else begin
      vw_out_q    <= vw_out_d;
      t_out_q     <= t_out_d;
      last_good_q <= last_good_d;
      seen_good_q <= seen_good_d;
      valid_q     <= valid_d;
      changed_q   <= changed_d;
      bad_q       <= bad_d;
      step_cnt_q  <= step_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign vw_out     = vw_out_q;
  assign t_out      = t_out_q;
  assign vw_valid   = valid_q;
  assign vw_changed = changed_q;
  assign vw_bad     = bad_q;
  assign step_cnt   = step_cnt_q;
  assign overrun    = overrun_q;

endmodule : vwind_sample_ctrl

// File: tb/tb_vwind_sample_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vwind_sample_ctrl
//   Self-checking bench for vwind_sample_ctrl: directed table of steps, a
//   reset-mid-OFFER sequence, then randomized steps against a transaction-level
//   reference model.
// -----------------------------------------------------------------------------
module tb_vwind_sample_ctrl;
  import global_parameter::*;

  localparam int D = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     sta;
  logic [SINGLE-1:0]        VWind;
  logic [WIDTH_TIME-1:0]    sim_time;
  logic                     rdy_out;
  logic [SINGLE-1:0]        vw_out;
  logic [WIDTH_TIME-1:0]    t_out;
  logic                     vw_valid;
  logic                     vw_changed;
  logic                     vw_bad;
  logic [WIDTH_STEPCNT-1:0] step_cnt;
  logic                     overrun;

  vwind_sample_ctrl #(.CAP_DELAY(D), .SW(SINGLE), .TW(WIDTH_TIME)) dut (
    .clk        (clk),
    .rst        (rst),
    .sta        (sta),
    .VWind      (VWind),
    .sim_time   (sim_time),
    .rdy_out    (rdy_out),
    .vw_out     (vw_out),
    .t_out      (t_out),
    .vw_valid   (vw_valid),
    .vw_changed (vw_changed),
    .vw_bad     (vw_bad),
    .step_cnt   (step_cnt),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".vw_out"},     64'(vw_out),     64'h0);
    check({tag, ".t_out"},      64'(t_out),      64'h0);
    check({tag, ".vw_valid"},   64'(vw_valid),   64'h0);
    check({tag, ".vw_changed"}, 64'(vw_changed), 64'h0);
    check({tag, ".vw_bad"},     64'(vw_bad),     64'h0);
    check({tag, ".step_cnt"},   64'(step_cnt),   64'h0);
    check({tag, ".overrun"},    64'(overrun),    64'h0);
  endtask

  // One complete simulation step, starting with sta sampled at the next edge.
  task automatic do_step(input logic [31:0] vw, input logic [31:0] t, input int stall,
                         input bit ov_wait, input bit ov_xfer,
                         input logic [31:0] e_out, input bit e_chg, input bit e_bad,
                         input logic [15:0] e_cnt, input bit e_ov, input string tag);
    sta = 1'b1; VWind = vw; sim_time = t; rdy_out = 1'b1;  // rdy ignored outside OFFER
    tick();                                                 // edge k
    sta = 1'b0;
    for (int i = 0; i < D; i++) begin                       // edges k+1..k+D in WAIT
      if (ov_wait && i == 0) sta = 1'b1;
      tick();
      sta = 1'b0;
    end
    check({tag, ".valid_pre"}, 64'(vw_valid), 64'h0);
    tick();                                                 // capture edge k+D+1
    VWind = ~vw; sim_time = ~t;                             // outputs must not follow
    rdy_out = (stall == 0);
    check({tag, ".valid"},   64'(vw_valid),   64'h1);
    check({tag, ".vw_out"},  64'(vw_out),     64'(e_out));
    check({tag, ".t_out"},   64'(t_out),      64'(t));
    check({tag, ".changed"}, 64'(vw_changed), 64'(e_chg));
    check({tag, ".bad"},     64'(vw_bad),     64'(e_bad));
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, ".stall_valid"}, 64'(vw_valid), 64'h1);
      check({tag, ".stall_out"},   64'(vw_out),   64'(e_out));
      check({tag, ".stall_cnt"},   64'(step_cnt), 64'(e_cnt - 16'd1));
    end
    rdy_out = 1'b1;
    if (ov_xfer) sta = 1'b1;
    tick();                                                 // transfer edge
    sta = 1'b0; rdy_out = 1'b0;
    check({tag, ".valid_post"}, 64'(vw_valid), 64'h0);
    check({tag, ".step_cnt"},   64'(step_cnt), 64'(e_cnt));
    check({tag, ".overrun"},    64'(overrun),  64'(e_ov));
    check({tag, ".hold_out"},   64'(vw_out),   64'(e_out));
  endtask

  typedef struct {
    logic [31:0] vw;
    logic [31:0] t;
    int          stall;
    bit          ov_wait;
    bit          ov_xfer;
    logic [31:0] e_out;
    bit          e_chg;
    bit          e_bad;
    logic [15:0] e_cnt;
    bit          e_ov;
  } vec_t;

  vec_t tbl[11];

  // Reference model state (transaction level)
  logic [31:0] m_last_good;
  bit          m_seen;
  logic [31:0] m_out;
  logic [15:0] m_cnt;
  bit          m_ov;

  initial begin
    tbl[0]  = '{32'h41400000,  100, 0, 1'b0, 1'b0, 32'h41400000, 1'b1, 1'b0, 16'd1,  1'b0};
    tbl[1]  = '{32'h41400000,  200, 0, 1'b0, 1'b0, 32'h41400000, 1'b0, 1'b0, 16'd2,  1'b0};
    tbl[2]  = '{32'h41600000,  300, 0, 1'b0, 1'b0, 32'h41600000, 1'b1, 1'b0, 16'd3,  1'b0};
    tbl[3]  = '{32'h41600000,  400, 7, 1'b0, 1'b0, 32'h41600000, 1'b0, 1'b0, 16'd4,  1'b0};
    tbl[4]  = '{32'h41400000,  500, 0, 1'b0, 1'b0, 32'h41400000, 1'b1, 1'b0, 16'd5,  1'b0};
    tbl[5]  = '{32'h7FC00000,  600, 0, 1'b0, 1'b0, 32'h41400000, 1'b0, 1'b1, 16'd6,  1'b0};
    tbl[6]  = '{32'h41400000,  700, 0, 1'b0, 1'b0, 32'h41400000, 1'b0, 1'b0, 16'd7,  1'b0};
    tbl[7]  = '{32'h7F800000,  800, 2, 1'b0, 1'b0, 32'h41400000, 1'b0, 1'b1, 16'd8,  1'b0};
    tbl[8]  = '{32'h80000000,  900, 0, 1'b0, 1'b0, 32'h80000000, 1'b1, 1'b0, 16'd9,  1'b0};
    tbl[9]  = '{32'h00000000, 1000, 0, 1'b1, 1'b1, 32'h00000000, 1'b1, 1'b0, 16'd10, 1'b1};
    tbl[10] = '{32'h00000000, 1100, 0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 16'd11, 1'b1};

    rst = 1'b1; sta = 1'b0; VWind = 32'h3F800000; sim_time = 32'd5; rdy_out = 1'b1;
    #1;
    check_reset_outputs("reset");
    tick();
    tick();
    #2 rst = 1'b0;
    repeat (6) tick();  // a few idle cycles before the first strobe

    // Directed table
    for (int i = 0; i < 11; i++)
      do_step(tbl[i].vw, tbl[i].t, tbl[i].stall, tbl[i].ov_wait, tbl[i].ov_xfer,
              tbl[i].e_out, tbl[i].e_chg, tbl[i].e_bad, tbl[i].e_cnt, tbl[i].e_ov,
              $sformatf("tbl%0d", i));

    // The overrun strobes must not have queued an extra capture.
    repeat (D + 4) tick();
    check("no_extra.valid", 64'(vw_valid), 64'h0);
    check("no_extra.cnt",   64'(step_cnt), 64'd11);

    // Reset in the middle of OFFER
    sta = 1'b1; VWind = 32'h41200000; sim_time = 32'd77; rdy_out = 1'b0;
    tick();
    sta = 1'b0;
    repeat (D + 1) tick();
    check("mid.valid_before", 64'(vw_valid), 64'h1);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    tick();
    #2 rst = 1'b0;
    tick();
    check("mid.valid_after", 64'(vw_valid), 64'h0);
    do_step(32'h41400000, 32'd1200, 0, 1'b0, 1'b0, 32'h41400000, 1'b1, 1'b0, 16'd1, 1'b0, "post_rst");

    m_last_good = 32'h41400000; m_seen = 1'b1; m_out = 32'h41400000; m_cnt = 16'd1; m_ov = 1'b0;

    // Randomized steps against the reference model
    for (int n = 0; n < 150; n++) begin
      logic [31:0] vw;
      logic [31:0] e_out;
      bit          bad, chg, ow, ox;
      int          r, stall;
      r  = int'($urandom_range(0, 99));
      vw = $urandom;
      if (r < 25)      vw = m_last_good;
      else if (r < 40) vw[30:23] = 8'hFF;
      else if (r < 45) vw = m_last_good ^ 32'h80000000;
      stall = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 4)) : 0;
      ow    = ($urandom_range(0, 9) == 0);
      ox    = ($urandom_range(0, 9) == 0);

      bad = (vw[30:23] == 8'hFF);
      if (bad) begin
        e_out = m_out;
        chg   = 1'b0;
      end else begin
        e_out = vw;
        chg   = !m_seen || (vw != m_last_good);
      end
      m_cnt = m_cnt + 16'd1;
      m_ov  = m_ov | ow | ox;

      do_step(vw, $urandom, stall, ow, ox, e_out, chg, bad, m_cnt, m_ov,
              $sformatf("rnd%0d", n));

      m_out = e_out;
      if (!bad) begin
        m_last_good = vw;
        m_seen      = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_vwind_sample_ctrl
